// File: rtl/nibble_serial_subtractor_16.sv
// 16-bit two's-complement subtractor, D = A - B, one nibble per clock through a
// single 4-bit carry-lookahead slice; the inter-nibble carry lives in a register.
module nibble_serial_subtractor_16 (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] D,
  output logic        Borrow,
  output logic        V,
  output logic        Zero,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  state_dbg
);

  // Handshake: Start is taken on a rising edge only while Busy=0; A and B are
  // sampled on that edge alone. Done pulses for one cycle, and D/Borrow/V/Zero
  // are valid from that cycle until the next Done.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] ra;
  logic [15:0] rb;
  logic [15:0] work;
  logic [1:0]  i;
  logic        c;

  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [3:0]  p;
  logic [3:0]  g;
  logic [3:0]  cin;
  logic [3:0]  sum;
  logic        pg;
  logic        gg;
  logic        c_next;
  logic [15:0] work_next;
  logic [3:0]  nib_base;

  assign state_dbg = state;
  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);
  assign nib_base  = {i, 2'b00};

  // Lookahead slice: rb already holds ~B, and the carry register starts at 1.
  always_comb begin
    nib_a  = ra[nib_base +: 4];
    nib_b  = rb[nib_base +: 4];
    p      = nib_a ^ nib_b;
    g      = nib_a & nib_b;
    cin[0] = c;
    cin[1] = g[0] | (p[0] & c);
    cin[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cin[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    sum    = p ^ cin;
    pg     = &p;
    gg     = g[3] | (g[2] & p[3]) | (g[1] & p[3] & p[2]) | (g[0] & p[3] & p[2] & p[1]);
    c_next = gg | (pg & c);
    work_next = work;
    work_next[nib_base +: 4] = sum;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (i == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= IDLE;
      ra     <= 16'h0000;
      rb     <= 16'h0000;
      work   <= 16'h0000;
      i      <= 2'd0;
      c      <= 1'b0;
      D      <= 16'h0000;
      Borrow <= 1'b0;
      V      <= 1'b0;
      Zero   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (Start) begin
            ra   <= A;
            rb   <= ~B;
            work <= 16'h0000;
            c    <= 1'b1;
            i    <= 2'd0;
          end
        end
        RUN: begin
          work <= work_next;
          c    <= c_next;
          i    <= i + 2'd1;
          if (i == 2'd3) begin
            D      <= work_next;
            Borrow <= ~c_next;
            // ~rb[15] is the latched B[15].
            V      <= (ra[15] ^ ~rb[15]) & (work_next[15] ^ ra[15]);
            Zero   <= ~|work_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor_16.sv
// Directed bench for nibble_serial_subtractor_16: hand-computed results go into
// a queue and a negedge monitor pops one per Done pulse.
module tb_nibble_serial_subtractor_16;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] d;
  logic        borrow;
  logic        v;
  logic        zero;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  logic [18:0] exp_q[$];
  int          pass_cnt;
  int          total_cnt;
  logic        rst_seen;
  logic        prev_done;
  logic [18:0] last_out;

  nibble_serial_subtractor_16 dut (
    .Clk       (clk),
    .Reset_n   (reset_n),
    .Start     (start),
    .A         (a),
    .B         (b),
    .D         (d),
    .Borrow    (borrow),
    .V         (v),
    .Zero      (zero),
    .Busy      (busy),
    .Done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rst_seen = 1'b1;
  always @(posedge clk) rst_seen = !reset_n;

  // ---------------- helpers ----------------
  function automatic logic [18:0] pk(input logic [15:0] dd, input logic bb,
                                     input logic vv, input logic zz);
    return {dd, bb, vv, zz};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    prev_done = 1'b0;
    last_out  = '0;
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      check("reset_outputs", {13'd0, d, borrow, v, zero}, 32'd0);
      check("reset_busy_done_state", {28'd0, busy, done, state_dbg}, 32'd0);
      last_out = '0;
    end else if (done) begin
      check("done_not_back_to_back", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", {13'd0, d, borrow, v, zero}, {13'd0, exp_q.pop_front()});
      end
      last_out = {d, borrow, v, zero};
    end else begin
      check("outputs_held", {13'd0, d, borrow, v, zero}, {13'd0, last_out});
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  // Issues one operation; A/B are scrambled right after the accepting edge.
  // poke > 0 re-pulses Start with other operands on that cycle after the accept.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic [18:0] exp, input int poke);
    int lat;
    int busy_cnt;
    bit ended;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b1;
    a = op_a;
    b = op_b;
    lat = 0;
    busy_cnt = 0;
    ended = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done && lat == 0) lat = n;
      if (n == 1) begin
        start = 1'b0;
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
      end
      if (poke > 0 && n == poke) begin
        start = 1'b1;
        a = 16'hFFFF;
        b = 16'h0000;
      end
      if (poke > 0 && n == poke + 1) start = 1'b0;
      if (!busy) begin
        ended = 1;
        break;
      end
    end
    check("op_finished", {31'd0, ended}, 32'd1);
    check("done_latency", lat, 5);
    check("busy_cycles", busy_cnt, 5);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_at[2];
    int dcount;
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    a       = 16'h0000;
    b       = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);

    // basic, borrow chains, overflow, zero
    run_op(16'h1234, 16'h0234, pk(16'h1000, 0, 0, 0), 0);
    run_op(16'h1000, 16'h0001, pk(16'h0FFF, 0, 0, 0), 0);
    run_op(16'h0000, 16'h0001, pk(16'hFFFF, 1, 0, 0), 0);
    run_op(16'h8000, 16'h0001, pk(16'h7FFF, 0, 1, 0), 0);
    run_op(16'h7FFF, 16'hFFFF, pk(16'h8000, 1, 1, 0), 0);
    run_op(16'h5A5A, 16'h5A5A, pk(16'h0000, 0, 0, 1), 0);
    idle_cycles(2);

    // Start pulsed during RUN, then during DONE: both ignored
    run_op(16'h0100, 16'h0001, pk(16'h00FF, 0, 0, 0), 2);
    run_op(16'h0001, 16'h0002, pk(16'hFFFF, 1, 0, 0), 5);
    idle_cycles(4);

    // Start held high: two operations, Done six cycles apart
    exp_q.push_back(pk(16'hFFF0, 1, 0, 0));
    exp_q.push_back(pk(16'h8000, 1, 1, 0));
    @(negedge clk);
    start = 1'b1;
    a = 16'h0010;
    b = 16'h0020;
    dcount = 0;
    done_at[0] = 0;
    done_at[1] = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a = 16'h4000;
        b = 16'hC000;
      end
      if (done) begin
        done_at[dcount] = n;
        dcount++;
        if (dcount == 2) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("held_done_count", dcount, 2);
    check("held_first_done", done_at[0], 5);
    check("held_done_period", done_at[1] - done_at[0], 6);
    idle_cycles(4);

    // reset after nibble 1 written: aborted, no Done
    @(negedge clk);
    start = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(8);

    run_op(16'h0003, 16'h0005, pk(16'hFFFE, 1, 0, 0), 0);
    idle_cycles(4);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    total_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
